// File: rtl/text_buffer_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_writer_if
//  Description : Character byte stream handshake into the text buffer writer.
//                The master drives char_in/char_valid; the slave answers with
//                char_ready. A byte moves on a rising edge where both are high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface text_buffer_writer_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready
    );
endinterface
`default_nettype wire

// File: rtl/text_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_writer
//  Description : Terminal-style text buffer. Accepts a byte stream, keeps a
//                cursor, handles newline/backspace/form feed, clears rows as
//                the cursor enters them, and serves 7-bit glyph codes to a
//                VGA renderer from the current pixel position.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_buffer_writer #(
    parameter int COLS = 32,
    parameter int ROWS = 4,
    parameter int X0   = 192,
    parameter int Y0   = 208
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    text_buffer_writer_if.slave            char_if,
    input  wire logic [9:0]                x,
    input  wire logic [9:0]                y,
    output logic [6:0]                     ascii_code,
    output logic [$clog2(COLS)-1:0]        cursor_col,
    output logic [$clog2(ROWS)-1:0]        cursor_row,
    output logic                           busy
);

    localparam int c_DEPTH = COLS * ROWS;
    localparam int c_AW    = $clog2(c_DEPTH);
    localparam int c_CW    = $clog2(COLS);
    localparam int c_RW    = $clog2(ROWS);

    localparam logic [1:0] c_ST_CLR_ALL = 2'd0;
    localparam logic [1:0] c_ST_IDLE    = 2'd1;
    localparam logic [1:0] c_ST_CLR_ROW = 2'd2;

    localparam logic [6:0] c_SPACE = 7'h20;

    logic [1:0]      r_state, w_state_nxt;
    logic [c_CW-1:0] r_col,   w_col_nxt;
    logic [c_RW-1:0] r_row,   w_row_nxt;
    logic [c_AW-1:0] r_cnt,   w_cnt_nxt;

    logic            w_we;
    logic [c_AW-1:0] w_waddr;
    logic [6:0]      w_wdata;
    logic [c_RW-1:0] w_row_inc;
    logic            w_accept;
    logic            w_in_win;
    logic [c_AW-1:0] w_raddr;

    logic [6:0]      r_mem [c_DEPTH];

    function automatic logic [c_AW-1:0] f_addr(input logic [c_RW-1:0] row,
                                               input logic [c_CW-1:0] col);
        return c_AW'(int'(row) * COLS + int'(col));
    endfunction

    assign w_accept  = char_if.char_valid && (r_state == c_ST_IDLE);
    assign w_row_inc = (r_row == c_RW'(ROWS - 1)) ? '0 : r_row + c_RW'(1);

    // State and cursor/counter registers; reset abandons any clear in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_CLR_ALL;
            r_col   <= '0;
            r_row   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, cursor movement and buffer write decode
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_waddr     = f_addr(r_row, r_col);
        w_wdata     = c_SPACE;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (char_if.char_in >= 8'h20 && char_if.char_in <= 8'h7E) begin
                        w_we    = 1'b1;
                        w_wdata = char_if.char_in[6:0];
                        if (r_col == c_CW'(COLS - 1)) begin
                            w_col_nxt   = '0;
                            w_row_nxt   = w_row_inc;
                            w_cnt_nxt   = '0;
                            w_state_nxt = c_ST_CLR_ROW;
                        end else begin
                            w_col_nxt = r_col + c_CW'(1);
                        end
                    end else if (char_if.char_in == 8'h0A || char_if.char_in == 8'h0D) begin
                        w_col_nxt   = '0;
                        w_row_nxt   = w_row_inc;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_CLR_ROW;
                    end else if (char_if.char_in == 8'h08) begin
                        // Backspace erases the cell it moves onto
                        if (r_col != '0) begin
                            w_col_nxt = r_col - c_CW'(1);
                            w_we      = 1'b1;
                            w_waddr   = f_addr(r_row, r_col - c_CW'(1));
                        end else if (r_row != '0) begin
                            w_row_nxt = r_row - c_RW'(1);
                            w_col_nxt = c_CW'(COLS - 1);
                            w_we      = 1'b1;
                            w_waddr   = f_addr(r_row - c_RW'(1), c_CW'(COLS - 1));
                        end
                    end else if (char_if.char_in == 8'h0C) begin
                        w_col_nxt   = '0;
                        w_row_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_ST_CLR_ALL;
                    end
                end
            end
            c_ST_CLR_ROW: begin
                w_we    = 1'b1;
                w_waddr = f_addr(r_row, r_cnt[c_CW-1:0]);
                if (r_cnt == c_AW'(COLS - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_AW'(1);
                end
            end
            default: begin
                // CLR_ALL, and recovery from the unused encoding
                w_we    = (r_state == c_ST_CLR_ALL);
                w_waddr = r_cnt;
                if (r_state != c_ST_CLR_ALL) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_CLR_ALL;
                end else if (r_cnt == c_AW'(c_DEPTH - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_AW'(1);
                end
            end
        endcase
    end

    // Handshake, status and cursor outputs
    always_comb begin
        char_if.char_ready = (r_state == c_ST_IDLE);
        busy               = (r_state != c_ST_IDLE);
        cursor_col         = r_col;
        cursor_row         = r_row;
    end

    // Buffer write port; contents need no reset since CLR_ALL follows reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign w_in_win = (int'(x) >= X0) && (int'(x) < X0 + 8 * COLS) &&
                      (int'(y) >= Y0) && (int'(y) < Y0 + 16 * ROWS);
    assign w_raddr  = c_AW'(((int'(y) - Y0) >>> 4) * COLS + ((int'(x) - X0) >>> 3));

    // Registered glyph lookup for the pixel scanner; blank outside the window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ascii_code <= c_SPACE;
        end else begin
            ascii_code <= w_in_win ? r_mem[w_raddr] : c_SPACE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_buffer_writer
//  Description : Scoreboard bench for text_buffer_writer. Stimulus pushes
//                expected values into queues; a monitor pops and compares
//                them one cycle after each request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_buffer_writer;

    localparam int K_ASCII  = 0;
    localparam int K_CURSOR = 1;
    localparam int K_RUN    = 2;
    localparam int K_READY  = 3;
    localparam int K_BUSY   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y;
    logic [6:0] ascii_code;
    logic [4:0] cursor_col;
    logic [1:0] cursor_row;
    logic       busy;

    text_buffer_writer_if cif ();

    text_buffer_writer dut (
        .clk        (clk),
        .reset      (reset),
        .char_if    (cif),
        .x          (x),
        .y          (y),
        .ascii_code (ascii_code),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int    kind_q[$];
    int    exp_q[$];
    string name_q[$];
    logic  chk_strobe = 1'b0;
    logic  chk_vld    = 1'b0;
    int    n_total    = 0;
    int    n_pass     = 0;
    int    busy_run   = 0;
    int    last_run   = 0;

    // Check requests become due one cycle after they are issued
    always @(posedge clk) chk_vld <= chk_strobe;

    // Monitor: tracks busy run length and compares due expectations
    always @(negedge clk) begin
        int    k, e, a;
        string nm;
        if (!reset) busy_run = 0;
        else if (busy) busy_run++;
        else if (busy_run > 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
        if (chk_vld) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_underflow: got empty queue required entry");
            end else begin
                k  = kind_q.pop_front();
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                case (k)
                    K_ASCII:  a = int'(ascii_code);
                    K_CURSOR: a = int'({cursor_row, cursor_col});
                    K_RUN:    a = last_run;
                    K_READY:  a = int'(cif.char_ready);
                    default:  a = int'(busy);
                endcase
                if (a == e) n_pass++;
                else $display("FAIL %s: got 0x%0h required 0x%0h", nm, a, e);
            end
        end
    end

    task automatic check(input int kind, input int exp, input string name);
        @(negedge clk);
        kind_q.push_back(kind);
        exp_q.push_back(exp);
        name_q.push_back(name);
        chk_strobe = 1'b1;
        @(negedge clk);
        chk_strobe = 1'b0;
    endtask

    task automatic scan(input int px, input int py, input int exp, input string name);
        x = 10'(px);
        y = 10'(py);
        check(K_ASCII, exp, name);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cif.char_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cif.char_ready) begin
            n_total++;
            $display("FAIL wait_ready: char_ready=0 required 1 within %0d cycles", n);
        end
    endtask

    task automatic send(input logic [7:0] c);
        wait_ready();
        cif.char_in    = c;
        cif.char_valid = 1'b1;
        @(negedge clk);
        cif.char_valid = 1'b0;
    endtask

    // cursor encoding used by the scoreboard: {row, col}
    function automatic int cur(input int col, input int row);
        return row * 32 + col;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        cif.char_in    = 8'h00;
        cif.char_valid = 1'b1;
        x              = 10'd192;
        y              = 10'd208;

        // Reset values
        check(K_BUSY,   1,     "reset_busy");
        check(K_READY,  0,     "reset_ready");
        check(K_CURSOR, 0,     "reset_cursor");
        check(K_ASCII,  'h20,  "reset_ascii");

        // Release with char_valid held: full clear before ready
        @(posedge clk); #1 reset = 1'b1;
        wait_ready();
        check(K_RUN,   128, "initial_clear_len");
        check(K_READY, 1,   "ready_after_clear");
        cif.char_valid = 1'b0;
        check(K_CURSOR, 0, "cursor_after_clear");
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                scan(192 + 8 * c + (c % 8), 208 + 16 * r + ((r * 5) % 16), 'h20,
                     $sformatf("blank_r%0d_c%0d", r, c));

        // Single printable char, then backspace over it
        send(8'h41);
        scan(192, 208, 'h41, "A_at_origin");
        check(K_CURSOR, cur(1, 0), "cursor_after_A");
        send(8'h08);
        scan(192, 208, 'h20, "A_erased");
        check(K_CURSOR, cur(0, 0), "cursor_after_bs");

        // Discarded bytes
        send(8'h85);
        send(8'h01);
        check(K_CURSOR, cur(0, 0), "cursor_after_discard");
        check(K_BUSY,   0,         "busy_after_discard");

        // Full row wraps to row 1 with a 32-cycle row clear
        for (int i = 0; i < 32; i++) send(8'(8'h21 + i));
        wait_ready();
        check(K_RUN,    32,        "row_clear_len");
        check(K_CURSOR, cur(0, 1), "cursor_after_row");
        for (int c = 0; c < 32; c++)
            scan(192 + 8 * c + 7, 208 + 5, 'h21 + c, $sformatf("row0_c%0d", c));
        for (int c = 0; c < 32; c += 4)
            scan(192 + 8 * c, 224 + 15, 'h20, $sformatf("row1_c%0d", c));
        scan(447, 223, 'h40, "win_right_edge_in");
        scan(448, 223, 'h20, "win_right_edge_out");
        scan(191, 208, 'h20, "win_left_edge_out");
        scan(200, 207, 'h20, "win_top_edge_out");
        scan(192, 271, 'h20, "win_bottom_edge_in");
        scan(192, 272, 'h20, "win_bottom_edge_out");

        // Backspace from (0,1) to (31,0)
        send(8'h08);
        check(K_CURSOR, cur(31, 0), "cursor_bs_row");
        scan(447, 208, 'h20, "bs_erased_c31");
        scan(439, 208, 'h3F, "bs_kept_c30");

        // Form feed
        send(8'h0C);
        wait_ready();
        check(K_RUN,    128,       "ff_clear_len");
        check(K_CURSOR, cur(0, 0), "cursor_after_ff");
        scan(439, 208, 'h20, "ff_cleared_c30");

        // Backspace at origin does nothing
        send(8'h08);
        check(K_CURSOR, cur(0, 0), "bs_at_origin");
        check(K_BUSY,   0,         "bs_at_origin_busy");

        // Walk rows, wrap from row 3 to row 0
        send(8'h58); send(8'h0D);
        send(8'h59); send(8'h0A);
        send(8'h5A); send(8'h0D);
        wait_ready();
        check(K_CURSOR, cur(0, 3), "cursor_row3");
        send(8'h57); send(8'h0D);
        wait_ready();
        check(K_RUN,    32,        "wrap_clear_len");
        check(K_CURSOR, cur(0, 0), "cursor_wrap");
        scan(192, 208, 'h20, "wrap_row0_cleared");
        scan(192, 224, 'h59, "wrap_row1_kept");
        scan(192, 240, 'h5A, "wrap_row2_kept");
        scan(192, 256, 'h57, "wrap_row3_kept");

        send(8'h0C);
        wait_ready();
        check(K_RUN,    128,       "ff2_clear_len");
        check(K_CURSOR, cur(0, 0), "cursor_after_ff2");
        scan(192, 256, 'h20, "ff2_row3_cleared");

        // Reset in the middle of a row clear
        send(8'h51);
        send(8'h0A);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        check(K_BUSY,   1,         "midclr_reset_busy");
        check(K_READY,  0,         "midclr_reset_ready");
        check(K_CURSOR, cur(0, 0), "midclr_reset_cursor");
        scan(192, 208, 'h20, "midclr_reset_ascii");
        @(posedge clk); #1 reset = 1'b1;
        wait_ready();
        check(K_RUN,    128,       "post_reset_clear_len");
        check(K_CURSOR, cur(0, 0), "post_reset_cursor");
        scan(100, 100, 'h20, "outside_100_100");
        scan(192, 208, 'h20, "Q_cleared_by_reset");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_leftover: got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_buffer_writer.md
TEXT_BUFFER_WRITER -- requirements
Module: text_buffer_writer

Interface
REQ-001 SHALL have parameter COLS, default 32, character columns in the text window.
REQ-002 SHALL have parameter ROWS, default 4, character rows in the text window.
REQ-003 SHALL have parameter X0, default 192, first pixel column of the text window.
REQ-004 SHALL have parameter Y0, default 208, first pixel row of the text window.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port char_in  input  8  incoming character byte.
REQ-008 SHALL have port char_valid  input  1  char_in is valid this cycle.
REQ-009 SHALL have port char_ready  output  1  block accepts a character this cycle.
REQ-010 SHALL have port x  input  10  current pixel column from the VGA sync generator.
REQ-011 SHALL have port y  input  10  current pixel row from the VGA sync generator.
REQ-012 SHALL have port ascii_code  output  7  character code for the glyph renderer.
REQ-013 SHALL have port cursor_col  output  5  current cursor column, 0..COLS-1.
REQ-014 SHALL have port cursor_row  output  2  current cursor row, 0..ROWS-1.
REQ-015 SHALL have port busy  output  1  a clear operation is in progress.

Function
REQ-016 SHALL store COLS*ROWS 7-bit codes in a buffer addressed as row*COLS+col.
REQ-017 SHALL accept a character on any rising edge where char_valid=1 and char_ready=1, and SHALL process it on that same edge.
REQ-018 SHALL drive char_ready=1 only in state IDLE.
REQ-019 SHALL implement three states: CLR_ALL, IDLE and CLR_ROW.
REQ-020 SHALL, in IDLE, on an accepted printable char (0x20..0x7E), write char_in[6:0] at the cursor.
- If col<COLS-1: col+1.
- Otherwise: col=0 and enter the next row (REQ-023).
REQ-021 SHALL, in IDLE, on an accepted 0x0A or 0x0D, set col=0 and enter the next row (REQ-023).
REQ-022 SHALL, in IDLE, on an accepted 0x08 (backspace):
- If col>0: col-1, then write 0x20 at the new position.
- If col=0 and row>0: row-1, col=COLS-1, then write 0x20 there.
- At (0,0): no change.
REQ-023 SHALL, on entering the next row, set row=(row+1) mod ROWS (ROWS-1 wraps to 0), then go to CLR_ROW.
REQ-024 SHALL, in CLR_ROW, write 0x20 to the COLS cells of the new row, one per cycle, over exactly COLS cycles, then return to IDLE.
REQ-025 SHALL, in IDLE, on an accepted 0x0C (form feed), set the cursor to (0,0) and go to CLR_ALL.
REQ-026 SHALL, in CLR_ALL, write 0x20 to all COLS*ROWS cells, one per cycle, over exactly COLS*ROWS cycles, then go to IDLE.
REQ-027 SHALL accept and discard every other byte, including any byte with char_in[7]=1, leaving the buffer and cursor unchanged.
REQ-028 SHALL drive busy=1 exactly while in CLR_ALL or CLR_ROW.
REQ-029 SHALL register ascii_code one cycle after x,y:
- Inside the window (X0<=x<X0+8*COLS and Y0<=y<Y0+16*ROWS): the buffer entry at col=(x-X0)>>3, row=(y-Y0)>>4.
- Outside the window: 0x20.
REQ-030 SHALL keep the read port independent of the write side; during a clear, reads return either the old or the new value of the cell being written.
REQ-031 SHALL drive cursor_col and cursor_row directly from the cursor registers.

Reset
REQ-032 SHALL, while reset=0, asynchronously force:
- state=CLR_ALL, clear counter=0
- cursor (0,0)
- char_ready=0, busy=1, ascii_code=0x20
REQ-033 SHALL, after reset releases, clear the whole buffer as in REQ-026 before asserting char_ready.
REQ-034 SHALL, if reset asserts mid-clear or mid-operation, abandon the operation and restart from the REQ-032 state.

Verification
REQ-035 Release reset, hold char_valid=1 -> char_ready=0 for 128 cycles, then 1; every window position reads 0x20.
REQ-036 Send "A" (0x41), then scan x=192,y=208 -> ascii_code=0x41 one cycle later, cursor=(1,0).
REQ-037 Send 32 printable chars -> cursor=(0,1), busy=1 for 32 cycles, row 1 reads 0x20, row 0 holds the 32 chars.
REQ-038 At cursor (0,1), send 0x08 -> cursor=(31,0), cell (31,0) reads 0x20; at (0,0), send 0x08 -> no change.
REQ-039 At row 3, send 0x0D -> cursor=(0,0) after a 32-cycle CLR_ROW, row 0 cleared, rows 1..3 intact; send 0x0C -> 128-cycle clear, cursor=(0,0).
REQ-040 Assert reset during CLR_ROW -> outputs take REQ-032 values immediately, and a full 128-cycle clear follows release; x=100,y=100 -> ascii_code=0x20.
